// File: rtl/axis_tri_capture_packer_if.sv
// Stream bundle for the three-channel capture packer: three sample input
// channels (s00..s02) and one packed frame output (m00).
// The slave modport is the packer's view; the master modport is the view of
// the surrounding sources and sink.
interface axis_tri_capture_packer_if #(
   parameter int C_AXIS_TDATA_WIDTH = 32
);
   logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata;
   logic                            s00_axis_tvalid;
   logic                            s00_axis_tready;
   logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata;
   logic                            s01_axis_tvalid;
   logic                            s01_axis_tready;
   logic [C_AXIS_TDATA_WIDTH-1:0]   s02_axis_tdata;
   logic                            s02_axis_tvalid;
   logic                            s02_axis_tready;
   logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata;
   logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb;
   logic                            m00_axis_tvalid;
   logic                            m00_axis_tready;
   logic                            m00_axis_tlast;

   modport slave (
      input  s00_axis_tdata, s00_axis_tvalid,
      output s00_axis_tready,
      input  s01_axis_tdata, s01_axis_tvalid,
      output s01_axis_tready,
      input  s02_axis_tdata, s02_axis_tvalid,
      output s02_axis_tready,
      output m00_axis_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
      input  m00_axis_tready
   );

   modport master (
      output s00_axis_tdata, s00_axis_tvalid,
      input  s00_axis_tready,
      output s01_axis_tdata, s01_axis_tvalid,
      input  s01_axis_tready,
      output s02_axis_tdata, s02_axis_tvalid,
      input  s02_axis_tready,
      input  m00_axis_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
      output m00_axis_tready
   );
endinterface

// File: rtl/axis_tri_capture_packer.sv
// Three-channel frame capture packer. Each channel fills its own bank with
// FRAME_LEN samples; once all three banks are full the banks are drained as
// one output frame (ch0, ch1, ch2) with tlast on the final word.
module axis_tri_capture_packer #(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int FRAME_LEN          = 2048,
   parameter int LEN_WIDTH          = 11
) (
   input  logic                        clk,
   input  logic                        rstn,
   axis_tri_capture_packer_if.slave    bus,
   output logic                        busy,
   output logic [15:0]                 frame_count
);
   localparam int W = C_AXIS_TDATA_WIDTH;
   localparam logic [LEN_WIDTH:0]   CNT_FULL = (LEN_WIDTH+1)'(FRAME_LEN);
   localparam logic [LEN_WIDTH-1:0] IDX_LAST = LEN_WIDTH'(FRAME_LEN - 1);

   typedef enum logic {CAPTURE, DRAIN} state_t;

   state_t               state;
   logic [LEN_WIDTH:0]   cnt [3];
   logic [W-1:0]         s_data [3];
   logic [2:0]           s_valid;
   logic [2:0]           s_ready;
   logic [2:0]           s_hs;
   logic [W-1:0]         bank [3][FRAME_LEN];

   // read pointer split into bank number and index; bank 3 means "all read"
   logic [1:0]           rd_bank;
   logic [LEN_WIDTH-1:0] rd_idx;
   logic                 rd_valid;
   logic                 rd_last;
   logic [W-1:0]         rd_data;
   logic                 out_valid;
   logic                 out_last;
   logic [W-1:0]         out_data;

   logic                 all_full;
   logic                 out_load;
   logic                 move;
   logic                 issue;
   logic                 last_hs;

   assign s_data[0] = bus.s00_axis_tdata;
   assign s_data[1] = bus.s01_axis_tdata;
   assign s_data[2] = bus.s02_axis_tdata;
   assign s_valid   = {bus.s02_axis_tvalid, bus.s01_axis_tvalid, bus.s00_axis_tvalid};

   assign bus.s00_axis_tready = s_ready[0];
   assign bus.s01_axis_tready = s_ready[1];
   assign bus.s02_axis_tready = s_ready[2];
   assign bus.m00_axis_tdata  = out_data;
   assign bus.m00_axis_tstrb  = '1;
   assign bus.m00_axis_tvalid = out_valid;
   assign bus.m00_axis_tlast  = out_last;
   assign busy                = (state == DRAIN);

   // handshakes, pipeline advance and read-issue decisions
   always_comb begin
      s_ready = '0;
      for (int k = 0; k < 3; k++) begin
         s_ready[k] = rstn && (state == CAPTURE) && (cnt[k] < CNT_FULL);
      end
      s_hs     = s_ready & s_valid;
      all_full = (cnt[0] == CNT_FULL) && (cnt[1] == CNT_FULL) && (cnt[2] == CNT_FULL);
      out_load = bus.m00_axis_tready || !out_valid;
      move     = rd_valid && out_load;
      issue    = (state == DRAIN) && (rd_bank != 2'd3) && (!rd_valid || move);
      last_hs  = out_valid && out_last && bus.m00_axis_tready;
   end

   // bank storage and bank read register; contents survive reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (s_hs[k]) bank[k][cnt[k][LEN_WIDTH-1:0]] <= s_data[k];
      end
      if (issue) rd_data <= bank[rd_bank][rd_idx];
   end

   // capture/drain state machine with counters, read pointer and output register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= CAPTURE;
         for (int k = 0; k < 3; k++) cnt[k] <= '0;
         rd_bank     <= '0;
         rd_idx      <= '0;
         rd_valid    <= 1'b0;
         rd_last     <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
         frame_count <= '0;
      end else begin
         case (state)
            CAPTURE: begin
               for (int k = 0; k < 3; k++) begin
                  if (s_hs[k]) cnt[k] <= cnt[k] + 1'b1;
               end
               if (all_full) state <= DRAIN;
            end
            DRAIN: begin
               if (issue) begin
                  rd_last <= (rd_bank == 2'd2) && (rd_idx == IDX_LAST);
                  if (rd_idx == IDX_LAST) begin
                     rd_idx  <= '0;
                     rd_bank <= rd_bank + 2'd1;
                  end else begin
                     rd_idx  <= rd_idx + 1'b1;
                  end
               end
               if (issue)     rd_valid <= 1'b1;
               else if (move) rd_valid <= 1'b0;
               if (out_load) begin
                  out_valid <= rd_valid;
                  out_last  <= rd_valid && rd_last;
                  if (rd_valid) out_data <= rd_data;
               end
               // frame complete: rearm capture on the same edge as the tlast handshake
               if (last_hs) begin
                  state       <= CAPTURE;
                  for (int k = 0; k < 3; k++) cnt[k] <= '0;
                  rd_bank     <= '0;
                  rd_idx      <= '0;
                  frame_count <= frame_count + 16'd1;
               end
            end
            default: state <= CAPTURE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_tri_capture_packer.sv
// Bench for axis_tri_capture_packer with FRAME_LEN = 4.
module tb_axis_tri_capture_packer;
   localparam int W  = 32;
   localparam int FL = 4;
   localparam int LW = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        busy;
   logic [15:0] frame_count;

   axis_tri_capture_packer_if #(.C_AXIS_TDATA_WIDTH(W)) bus ();

   axis_tri_capture_packer #(
      .C_AXIS_TDATA_WIDTH(W),
      .FRAME_LEN(FL),
      .LEN_WIDTH(LW)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus),
      .busy(busy),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   logic [W-1:0] td [3];
   logic [2:0]   tv;
   logic [2:0]   tr;
   logic         m_rdy;

   assign bus.s00_axis_tdata  = td[0];
   assign bus.s01_axis_tdata  = td[1];
   assign bus.s02_axis_tdata  = td[2];
   assign bus.s00_axis_tvalid = tv[0];
   assign bus.s01_axis_tvalid = tv[1];
   assign bus.s02_axis_tvalid = tv[2];
   assign bus.m00_axis_tready = m_rdy;
   assign tr = {bus.s02_axis_tready, bus.s01_axis_tready, bus.s00_axis_tready};

   int checks = 0;
   int errors = 0;

   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];
   logic [W-1:0] q2 [$];
   logic [W:0]   obs_q [$];
   logic [W-1:0] base [3];
   int           sent [3];
   bit           out_hs_last;
   bit           drop_seen;

   task automatic push_exp(input int k, input logic [W-1:0] d);
      case (k)
         0: q0.push_back(d);
         1: q1.push_back(d);
         default: q2.push_back(d);
      endcase
   endtask

   task automatic pop_exp(input int k, output logic [W-1:0] d, output bit ok);
      ok = 1'b0;
      d  = '0;
      case (k)
         0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
         2: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
         default: ok = 1'b0;
      endcase
   endtask

   // one clock: observe handshakes at the falling edge, return 1 time unit after the rising edge
   task automatic tick();
      @(negedge clk);
      out_hs_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (tv[k] && tr[k]) begin
            push_exp(k, td[k]);
            sent[k]++;
         end
      end
      if (bus.m00_axis_tvalid && m_rdy) begin
         obs_q.push_back({bus.m00_axis_tlast, bus.m00_axis_tdata});
         out_hs_last = bus.m00_axis_tlast;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) td[k] = base[k] + W'(sent[k]);
   endtask

   // mode 0: all channels in lockstep; mode 1: ch0 every cycle, ch1 every 3rd, ch2 with a 5-cycle gap
   task automatic load_frame(input logic [W-1:0] b0, input logic [W-1:0] b1,
                             input logic [W-1:0] b2, input int mode);
      int fc;
      base[0] = b0; base[1] = b1; base[2] = b2;
      for (int k = 0; k < 3; k++) begin
         sent[k] = 0;
         td[k]   = base[k];
      end
      fc = 0;
      drop_seen = 1'b0;
      while (!(sent[0] == FL && sent[1] == FL && sent[2] == FL) && fc < 100) begin
         if (mode == 0) begin
            for (int k = 0; k < 3; k++) tv[k] = (sent[k] < FL);
         end else begin
            tv[0] = 1'b1;
            tv[1] = (fc % 3 == 0) && (sent[1] < FL);
            tv[2] = !(fc >= 1 && fc <= 5) && (sent[2] < FL);
         end
         tick();
         fc++;
         if (sent[0] == FL && sent[1] < FL && tr[0] == 1'b0 && tr[1] == 1'b1) drop_seen = 1'b1;
      end
      tv = '0;
      if (fc >= 100) begin
         checks++;
         errors++;
         $display("FAIL capture_timeout sent=%0d/%0d/%0d required=%0d each", sent[0], sent[1], sent[2], FL);
      end
   endtask

   task automatic drain_frame(input bit bp, output bit done);
      int g;
      g = 0;
      done = 1'b0;
      while (!done && g < 200) begin
         m_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         g++;
         if (out_hs_last) done = 1'b1;
      end
      m_rdy = 1'b1;
   endtask

   task automatic test_reset();
      tv = 3'b111;
      m_rdy = 1'b1;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (tr !== 3'b000) begin errors++; $display("FAIL rst_tready got=%b required=000", tr); end
      checks++; if (bus.m00_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b required=0", bus.m00_axis_tvalid); end
      checks++; if (bus.m00_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got=%h required=0", bus.m00_axis_tdata); end
      checks++; if (bus.m00_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got=%b required=0", bus.m00_axis_tlast); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
      checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count got=%0d required=0", frame_count); end
      checks++; if (bus.m00_axis_tstrb !== 4'hF) begin errors++; $display("FAIL tstrb got=%h required=f", bus.m00_axis_tstrb); end
      tv = 3'b000;
      rstn = 1'b1;
      #1;
      checks++; if (tr !== 3'b111) begin errors++; $display("FAIL rel_tready got=%b required=111", tr); end
   endtask

   task automatic test_basic();
      int lat, beats, g;
      logic [W:0] got, expv;
      logic [W-1:0] ed;
      bit ok;
      m_rdy = 1'b1;
      load_frame(32'h100, 32'h200, 32'h300, 0);
      lat = 0;
      while (!bus.m00_axis_tvalid && lat < 20) begin
         tick();
         lat++;
         if (lat == 1) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start got=%b required=1", busy); end
         end
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL first_valid_latency got=%0d required=3", lat); end
      beats = 0;
      g = 0;
      while (beats < 3*FL && g < 50) begin
         tick();
         g++;
         while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            pop_exp(beats / FL, ed, ok);
            expv = {beats == 3*FL-1, ed};
            checks++;
            if (!ok || got !== expv) begin errors++; $display("FAIL basic_beat%0d got=%h required=%h", beats, got, expv); end
            beats++;
         end
         if (beats < 3*FL) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_drain got=%b required=1", busy); end
         end
      end
      checks++; if (g != 3*FL) begin errors++; $display("FAIL basic_beat_cycles got=%0d required=%0d", g, 3*FL); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end got=%b required=0", busy); end
      checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count got=%0d required=1", frame_count); end
   endtask

   task automatic test_back_to_back();
      int beats;
      logic [W:0] got, expv;
      logic [W-1:0] ed;
      bit ok, done;
      load_frame(32'h400, 32'h500, 32'h600, 0);
      drain_frame(1'b0, done);
      checks++; if (!done) begin errors++; $display("FAIL b2b_drain_timeout got=0 required=1"); end
      checks++; if (tr !== 3'b111) begin errors++; $display("FAIL b2b_tready_rearm got=%b required=111", tr); end
      beats = 0;
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front();
         pop_exp(beats / FL, ed, ok);
         expv = {beats == 3*FL-1, ed};
         checks++;
         if (!ok || got !== expv) begin errors++; $display("FAIL b2b_beat%0d got=%h required=%h", beats, got, expv); end
         beats++;
      end
      checks++; if (beats != 3*FL) begin errors++; $display("FAIL b2b_beats got=%0d required=%0d", beats, 3*FL); end
      checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL b2b_frame_count got=%0d required=2", frame_count); end
   endtask

   task automatic test_unequal_rates();
      int beats;
      logic [W:0] got, expv;
      logic [W-1:0] ed;
      bit ok, done;
      load_frame(32'h100, 32'h200, 32'h300, 1);
      checks++; if (!drop_seen) begin errors++; $display("FAIL ch0_tready_drop got=0 required=1"); end
      drain_frame(1'b0, done);
      checks++; if (!done) begin errors++; $display("FAIL unequal_drain_timeout got=0 required=1"); end
      beats = 0;
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front();
         pop_exp(beats / FL, ed, ok);
         expv = {beats == 3*FL-1, ed};
         checks++;
         if (!ok || got !== expv) begin errors++; $display("FAIL unequal_beat%0d got=%h required=%h", beats, got, expv); end
         beats++;
      end
      checks++; if (beats != 3*FL) begin errors++; $display("FAIL unequal_beats got=%0d required=%0d", beats, 3*FL); end
      checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL unequal_frame_count got=%0d required=3", frame_count); end
   endtask

   task automatic test_backpressure();
      int beats, g;
      logic [W:0] got, expv;
      logic [W-1:0] ed, hd;
      logic hv, hl;
      bit ok;
      load_frame(32'hA00, 32'hB00, 32'hC00, 0);
      beats = 0;
      g = 0;
      while (beats < 3*FL && g < 200) begin
         m_rdy = 1'($urandom_range(0, 1));
         hv = bus.m00_axis_tvalid;
         hd = bus.m00_axis_tdata;
         hl = bus.m00_axis_tlast;
         tick();
         g++;
         if (hv && !m_rdy) begin
            checks++;
            if ({bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tdata} !== {1'b1, hl, hd}) begin
               errors++;
               $display("FAIL stall_hold got=%b/%b/%h required=1/%b/%h", bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tdata, hl, hd);
            end
         end
         if (busy) begin
            checks++; if (tr !== 3'b000) begin errors++; $display("FAIL drain_tready got=%b required=000", tr); end
         end
         while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            pop_exp(beats / FL, ed, ok);
            expv = {beats == 3*FL-1, ed};
            checks++;
            if (!ok || got !== expv) begin errors++; $display("FAIL bp_beat%0d got=%h required=%h", beats, got, expv); end
            beats++;
         end
      end
      m_rdy = 1'b1;
      checks++; if (beats != 3*FL) begin errors++; $display("FAIL bp_beats got=%0d required=%0d", beats, 3*FL); end
      repeat (4) tick();
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra_beats got=%0d required=0", obs_q.size()); end
      checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL bp_frame_count got=%0d required=4", frame_count); end
   endtask

   task automatic test_reset_mid_drain();
      int beats, g;
      logic [W:0] got, expv;
      logic [W-1:0] ed;
      bit ok, done;
      m_rdy = 1'b1;
      load_frame(32'h700, 32'h710, 32'h720, 0);
      g = 0;
      while (obs_q.size() < 5 && g < 50) begin
         tick();
         g++;
      end
      beats = 0;
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front();
         pop_exp(beats / FL, ed, ok);
         expv = {beats == 3*FL-1, ed};
         checks++;
         if (!ok || got !== expv) begin errors++; $display("FAIL pre_rst_beat%0d got=%h required=%h", beats, got, expv); end
         beats++;
      end
      checks++; if (bus.m00_axis_tvalid !== 1'b1) begin errors++; $display("FAIL pre_rst_tvalid got=%b required=1", bus.m00_axis_tvalid); end
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (bus.m00_axis_tvalid !== 1'b0) begin errors++; $display("FAIL async_rst_tvalid got=%b required=0", bus.m00_axis_tvalid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b required=0", busy); end
      checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL async_rst_frame_count got=%0d required=0", frame_count); end
      q0.delete(); q1.delete(); q2.delete(); obs_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      load_frame(32'h800, 32'h900, 32'hA00, 0);
      drain_frame(1'b0, done);
      checks++; if (!done) begin errors++; $display("FAIL post_rst_drain_timeout got=0 required=1"); end
      beats = 0;
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front();
         pop_exp(beats / FL, ed, ok);
         expv = {beats == 3*FL-1, ed};
         checks++;
         if (!ok || got !== expv) begin errors++; $display("FAIL post_rst_beat%0d got=%h required=%h", beats, got, expv); end
         beats++;
      end
      checks++; if (beats != 3*FL) begin errors++; $display("FAIL post_rst_beats got=%0d required=%0d", beats, 3*FL); end
      checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL post_rst_frame_count got=%0d required=1", frame_count); end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         td[k]   = '0;
         base[k] = '0;
         sent[k] = 0;
      end
      tv = '0;
      m_rdy = 1'b1;
      out_hs_last = 1'b0;
      drop_seen = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_unequal_rates();
      test_backpressure();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
